signed_divider: RTL and testbench

//  Sequential signed divider, the inverse of the booth multiplier: divides a 2n-bit signed Dividend
//  (e.g. a booth Product) by an n-bit signed Divisor, giving n-bit Quotient and Remainder.

---
 rtl/signed_divider_pkg.sv | 11 +
 rtl/signed_divider_cond_negate.sv | 12 +
 rtl/signed_divider.sv | 172 +++++++++++++++++
 tb/tb_signed_divider.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/signed_divider_pkg.sv
// Shared names for the sequential arithmetic controllers (divider and booth multiplier).
package signed_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/signed_divider_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -a : a.
module cond_negate #(
  parameter int w = 8
) (
  input  logic         neg,
  input  logic [w-1:0] a,
  output logic [w-1:0] y
);

  assign y = neg ? (~a + w'(1)) : a;

endmodule

// File: rtl/signed_divider.sv
// Sequential signed restoring divider: 2n-bit dividend / n-bit divisor, one quotient bit per clock.
//
// Handshake: Start is sampled only in S_IDLE; Done is high for the whole of S_DONE, and the block
// stays in S_DONE while Start remains high, so one held Start yields exactly one operation.
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int n = 8
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           Start,
  input  logic [2*n-1:0] Dividend,
  input  logic [n-1:0]   Divisor,
  output logic           Done,
  output logic [n-1:0]   Quotient,
  output logic [n-1:0]   Remainder,
  output logic           Overflow,
  output logic           DivZero,
  output state_e         dbg_state
);

  localparam int CW = $clog2(n + 1);
  localparam logic [n-1:0] POS_LIM = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0] NEG_LIM = {1'b1, {(n-1){1'b0}}};

  state_e         state_q, state_d;
  logic [n-1:0]   rem_q, rem_d;
  logic [n-1:0]   quo_q, quo_d;
  logic [n-1:0]   dv_mag_q, dv_mag_d;
  logic [CW-1:0]  count_q, count_d;
  logic           qneg_q, qneg_d;
  logic           dneg_q, dneg_d;
  logic           err_q, err_d;
  logic           dz_q, dz_d;
  logic           done_q, done_d;
  logic [n-1:0]   quot_out_q, quot_out_d;
  logic [n-1:0]   rem_out_q, rem_out_d;
  logic           ovf_q, ovf_d;
  logic           divz_q, divz_d;

  logic [2*n-1:0] dd_mag;
  logic [n-1:0]   dv_mag;
  logic [n-1:0]   quo_signed;
  logic [n-1:0]   rem_signed;
  logic [n:0]     shifted;
  logic [n:0]     trial;
  logic           dv_zero;
  logic           pre_err;
  logic           range_ovf;

  cond_negate #(.w(2*n)) u_dd_abs (.neg(Dividend[2*n-1]), .a(Dividend), .y(dd_mag));
  cond_negate #(.w(n))   u_dv_abs (.neg(Divisor[n-1]),    .a(Divisor),  .y(dv_mag));
  cond_negate #(.w(n))   u_q_fix  (.neg(qneg_q),          .a(quo_q),    .y(quo_signed));
  cond_negate #(.w(n))   u_r_fix  (.neg(dneg_q),          .a(rem_q),    .y(rem_signed));

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dv_mag_d   = dv_mag_q;
    count_d    = count_q;
    qneg_d     = qneg_q;
    dneg_d     = dneg_q;
    err_d      = err_q;
    dz_d       = dz_q;
    done_d     = done_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    ovf_d      = ovf_q;
    divz_d     = divz_q;

    // The partial remainder always stays below |Divisor|, so the trial result fits in n bits.
    shifted   = {rem_q, quo_q[n-1]};
    trial     = shifted - {1'b0, dv_mag_q};
    dv_zero   = (Divisor == '0);
    // An upper half >= |Divisor| means the magnitude quotient needs more than n bits.
    pre_err   = dv_zero || (dd_mag[2*n-1:n] >= dv_mag);
    range_ovf = qneg_q ? (quo_q > NEG_LIM) : (quo_q > POS_LIM);

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          rem_d    = dd_mag[2*n-1:n];
          quo_d    = dd_mag[n-1:0];
          dv_mag_d = dv_mag;
          qneg_d   = Dividend[2*n-1] ^ Divisor[n-1];
          dneg_d   = Dividend[2*n-1];
          count_d  = '0;
          dz_d     = dv_zero;
          err_d    = pre_err;
          state_d  = pre_err ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (!trial[n]) begin
          rem_d = trial[n-1:0];
          quo_d = {quo_q[n-2:0], 1'b1};
        end else begin
          rem_d = shifted[n-1:0];
          quo_d = {quo_q[n-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(n - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (err_q || range_ovf) begin
          quot_out_d = '0;
          rem_out_d  = '0;
          ovf_d      = 1'b1;
          divz_d     = dz_q;
        end else begin
          quot_out_d = quo_signed;
          rem_out_d  = rem_signed;
          ovf_d      = 1'b0;
          divz_d     = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!Start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dv_mag_q   <= '0;
      count_q    <= '0;
      qneg_q     <= 1'b0;
      dneg_q     <= 1'b0;
      err_q      <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      ovf_q      <= 1'b0;
      divz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dv_mag_q   <= dv_mag_d;
      count_q    <= count_d;
      qneg_q     <= qneg_d;
      dneg_q     <= dneg_d;
      err_q      <= err_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      ovf_q      <= ovf_d;
      divz_q     <= divz_d;
    end
  end

  assign Done      = done_q;
  assign Quotient  = quot_out_q;
  assign Remainder = rem_out_q;
  assign Overflow  = ovf_q;
  assign DivZero   = divz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider: hand-computed vectors, latency, handshake and async reset.
module tb_signed_divider;
  import signed_divider_pkg::*;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        overflow;
  logic        div_zero;
  state_e      dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [17:0] exp_q[$];

  signed_divider #(.n(8)) dut (
    .Clock     (clock),
    .Resetn    (resetn),
    .Start     (start),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .Done      (done),
    .Quotient  (quotient),
    .Remainder (remainder),
    .Overflow  (overflow),
    .DivZero   (div_zero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #20 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Start is held for 'hold' edges beginning with the accepting edge E0.
  task automatic run_div(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                         input int hold, input int exp_lat, input logic [7:0] eq,
                         input logic [7:0] er, input logic eo, input logic ez);
    int          lat;
    int          drops;
    bit          finished;
    logic [17:0] e;
    exp_q.push_back({ez, eo, eq, er});
    @(negedge clock);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    lat      = -1;
    drops    = 0;
    finished = 1'b0;
    for (int k = 0; k < 60 && !finished; k++) begin
      @(posedge clock);
      #1;
      if (done && lat < 0) lat = k;
      if (lat >= 0 && start && !done) drops++;
      if (!start && lat >= 0 && !done) finished = 1'b1;
      else begin
        @(negedge clock);
        if (k + 1 >= hold) start = 1'b0;
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check({tag, ".completed"}, 32'(finished), 32'd1);
    check({tag, ".latency"},   32'(lat),      32'(exp_lat));
    check({tag, ".quotient"},  32'(quotient), 32'(e[15:8]));
    check({tag, ".remainder"}, 32'(remainder), 32'(e[7:0]));
    check({tag, ".overflow"},  32'(overflow), 32'(e[16]));
    check({tag, ".divzero"},   32'(div_zero), 32'(e[17]));
    check({tag, ".done_held"}, 32'(drops),    32'd0);
    check({tag, ".idle"},      32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #50;
    check("rst.done",      32'(done),      32'd0);
    check("rst.quotient",  32'(quotient),  32'd0);
    check("rst.remainder", 32'(remainder), 32'd0);
    check("rst.overflow",  32'(overflow),  32'd0);
    check("rst.divzero",   32'(div_zero),  32'd0);
    check("rst.state",     32'(dbg_state), 32'(S_IDLE));
    @(negedge clock);
    resetn = 1'b1;

    //       tag           dividend   divisor hold lat  Q      R      ovf   dz
    run_div("t1_pos",      16'h1452, 8'h33,  1,   9,   8'h66, 8'h00, 1'b0, 1'b0);
    run_div("t2_negdd",    16'hDC24, 8'h66,  1,   9,   8'hA6, 8'h00, 1'b0, 1'b0);
    run_div("t3_trunc",    16'hFFF9, 8'h02,  1,   9,   8'hFD, 8'hFF, 1'b0, 1'b0);
    run_div("t4_minq",     16'h4000, 8'h80,  1,   9,   8'h80, 8'h00, 1'b0, 1'b0);
    run_div("t4_rangeovf", 16'h4000, 8'h7F,  1,   9,   8'h00, 8'h00, 1'b1, 1'b0);
    run_div("t4_preovf",   16'h4000, 8'hFF,  1,   1,   8'h00, 8'h00, 1'b1, 1'b0);
    run_div("t5_divzero",  16'h1234, 8'h00,  1,   1,   8'h00, 8'h00, 1'b1, 1'b1);
    run_div("x_small",     16'h0064, 8'h07,  1,   9,   8'h0E, 8'h02, 1'b0, 1'b0);
    run_div("x_negdv",     16'h0007, 8'hFE,  1,   9,   8'hFD, 8'h01, 1'b0, 1'b0);
    run_div("x_minq_neg",  16'hC080, 8'h7F,  1,   9,   8'h80, 8'h00, 1'b0, 1'b0);
    run_div("x_mindd",     16'h8000, 8'h7F,  1,   1,   8'h00, 8'h00, 1'b1, 1'b0);
    run_div("t6_held_err", 16'h1234, 8'h00,  6,   1,   8'h00, 8'h00, 1'b1, 1'b1);
    run_div("t6_held_ok",  16'h1452, 8'h33,  12,  9,   8'h66, 8'h00, 1'b0, 1'b0);
    run_div("t3_again",    16'hFFF9, 8'h02,  1,   9,   8'hFD, 8'hFF, 1'b0, 1'b0);

    // Abort mid-CALC: outputs hold nonzero results from the previous operation until reset.
    @(negedge clock);
    dividend = 16'h1452;
    divisor  = 8'h33;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("abort.in_calc", 32'(dbg_state), 32'(S_CALC));
    #5;
    resetn = 1'b0;
    #1;
    check("abort.done",      32'(done),      32'd0);
    check("abort.quotient",  32'(quotient),  32'd0);
    check("abort.remainder", 32'(remainder), 32'd0);
    check("abort.overflow",  32'(overflow),  32'd0);
    check("abort.divzero",   32'(div_zero),  32'd0);
    check("abort.state",     32'(dbg_state), 32'(S_IDLE));
    @(negedge clock);
    resetn = 1'b1;
    run_div("t6_after_rst", 16'h1452, 8'h33, 1, 9, 8'h66, 8'h00, 1'b0, 1'b0);

    // With Start low, the idle block must not start another operation.
    repeat (3) @(posedge clock);
    #1;
    check("idle.no_retrigger", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
